// File: rtl/dmem_pkg.sv
// Shared funct3 codes and access-decode helpers for the RV32 data memory
// and its load-alignment path.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] offset);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << offset;
            F3_H, F3_HU: be = 4'b0011 << offset;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = (offset != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/half from a 32-bit word and sign/zero-extends it.
// Purely combinational so the cache-fill path can reuse it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_memory_rv.sv
// Byte-addressed RV32 data memory: lane-enabled stores, registered extended loads,
// and one-cycle fault strobes for misaligned or illegal-size requests.
module data_memory_rv
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  read_valid,
    output logic                  misaligned,
    output logic                  illegal
);

    localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            offset;
    logic                  req_store, req_load;
    logic                  bad_f3, bad_align;
    logic                  do_store, do_load;
    logic [3:0]            lane_en;
    logic [31:0]           wdata_lanes;
    logic [31:0]           load_data;

    always_comb begin
        word_idx  = address[ADDR_WIDTH-1:2];
        offset    = address[1:0];
        // A write wins over a simultaneous read, so store rules decide legality.
        req_store = mem_write;
        req_load  = mem_read & ~mem_write;
        if (req_store) begin
            bad_f3 = ~store_f3_ok(funct3);
        end else if (req_load) begin
            bad_f3 = ~load_f3_ok(funct3);
        end else begin
            bad_f3 = 1'b0;
        end
        bad_align = (req_store | req_load) & ~bad_f3 & is_misaligned(funct3, offset);
        do_store  = req_store & ~bad_f3 & ~bad_align;
        do_load   = req_load & ~bad_f3 & ~bad_align;
        lane_en   = byte_enable(funct3, offset) & {4{do_store}};
        case (funct3)
            F3_B:    wdata_lanes = {4{write_data[7:0]}};
            F3_H:    wdata_lanes = {2{write_data[15:0]}};
            default: wdata_lanes = write_data;
        endcase
    end

    dmem_load_align u_load_align (
        .word   (mem[word_idx]),
        .offset (offset),
        .funct3 (funct3),
        .data   (load_data)
    );

    // Array lives in the reset process only so a store on a reset edge is dropped;
    // the reset branch deliberately leaves contents untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data  <= 32'b0;
            read_valid <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
            if (do_load) read_data <= load_data;
            read_valid <= do_load;
            misaligned <= bad_align;
            illegal    <= bad_f3;
        end
    end

endmodule

// File: tb/tb_data_memory_rv.sv
// Scoreboard bench for data_memory_rv: directed scenarios plus random traffic
// against a byte-array reference model.
module tb_data_memory_rv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [11:0] address = 12'b0;
    logic [31:0] write_data = 32'b0;
    logic [31:0] read_data;
    logic        read_valid, misaligned, illegal;

    data_memory_rv #(.ADDR_WIDTH(12), .INIT_FILE("")) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  flags;   // {read_valid, misaligned, illegal}
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  mdl [4096];
    logic [31:0] rd_model = 32'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [11:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = mdl[a];
        h = {mdl[a + 12'd1], mdl[a]};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'b0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'b0, h};
            default: return {mdl[a + 12'd3], mdl[a + 12'd2], h};
        endcase
    endfunction

    // Issue one request for the next edge and record what the DUT must show after it.
    task automatic req(input logic wr, input logic rd, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] wd,
                       input bit use_c, input logic [31:0] cval);
        exp_t e;
        bit   st, ld, ill, mis;
        @(negedge clk);
        mem_write = wr; mem_read = rd; funct3 = f3; address = a; write_data = wd;
        st  = wr;
        ld  = rd && !wr;
        ill = st ? !(f3 inside {3'd0, 3'd1, 3'd2})
                 : (ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : 1'b0);
        mis = (st || ld) && !ill &&
              ((((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'b00)));
        e.cyc = cyc + 1;
        if (ill || mis) begin
            e.flags = {1'b0, mis, ill};
            e.data  = rd_model;
            q.push_back(e);
        end else if (st) begin
            mdl[a] = wd[7:0];
            if (f3 != 3'd0) mdl[a + 12'd1] = wd[15:8];
            if (f3 == 3'd2) begin
                mdl[a + 12'd2] = wd[23:16];
                mdl[a + 12'd3] = wd[31:24];
            end
        end else if (ld) begin
            rd_model = use_c ? cval : model_load(f3, a);
            e.flags  = 3'b100;
            e.data   = rd_model;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    // Monitor: compare whenever a strobe appears or an expected one is overdue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (read_valid || misaligned || illegal || (q.size() > 0 && q[0].cyc <= cyc)) begin
                if (q.size() == 0) begin
                    chk("spurious_strobe", {29'b0, read_valid, misaligned, illegal}, 32'b0);
                end else begin
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("flags", {29'b0, read_valid, misaligned, illegal}, {29'b0, e.flags});
                    chk("read_data", read_data, e.data);
                end
            end
        end
    end

    initial begin
        logic [2:0] f3_list [6];
        f3_list = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_read_data", read_data, 32'b0);
        chk("reset_read_valid", {31'b0, read_valid}, 32'b0);
        chk("reset_misaligned", {31'b0, misaligned}, 32'b0);
        chk("reset_illegal", {31'b0, illegal}, 32'b0);
        @(negedge clk);
        rst = 1'b0;

        // Give words 0x000-0x0FF known contents.
        for (int w = 0; w < 64; w++) req(1, 0, 3'd2, 12'(w * 4), $urandom, 0, 0);

        req(1, 0, 3'd2, 12'h014, 32'hDEADBEEF, 0, 0);
        req(0, 1, 3'd2, 12'h014, 0, 1, 32'hDEADBEEF);
        req(1, 0, 3'd0, 12'h015, 32'h123456AA, 0, 0);
        req(0, 1, 3'd2, 12'h014, 0, 1, 32'hDEADAAEF);
        req(0, 1, 3'd0, 12'h015, 0, 1, 32'hFFFFFFAA);
        req(0, 1, 3'd4, 12'h015, 0, 1, 32'h000000AA);
        req(1, 0, 3'd1, 12'h02A, 32'hFFFF8001, 0, 0);
        req(0, 1, 3'd1, 12'h02A, 0, 1, 32'hFFFF8001);
        req(0, 1, 3'd5, 12'h02A, 0, 1, 32'h00008001);
        req(0, 1, 3'd5, 12'h028, 0, 0, 0);
        idle();
        req(0, 1, 3'd2, 12'h016, 0, 0, 0);
        req(1, 0, 3'd1, 12'h011, 32'h0000BEEF, 0, 0);
        idle();
        req(0, 1, 3'd2, 12'h010, 0, 0, 0);
        req(0, 1, 3'd3, 12'h014, 0, 0, 0);
        req(1, 0, 3'd4, 12'h014, 32'h00000055, 0, 0);
        req(0, 1, 3'd2, 12'h014, 0, 1, 32'hDEADAAEF);
        req(1, 1, 3'd2, 12'h018, 32'hCAFEF00D, 0, 0);
        req(0, 1, 3'd2, 12'h018, 0, 1, 32'hCAFEF00D);

        // Reset mid-cycle after a load edge clears outputs at once.
        req(0, 1, 3'd2, 12'h018, 0, 1, 32'hCAFEF00D);
        @(posedge clk);
        #2;
        mem_read = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_read_data", read_data, 32'b0);
        chk("midreset_read_valid", {31'b0, read_valid}, 32'b0);
        rd_model = 32'b0;
        #4;
        rst = 1'b0;
        req(0, 1, 3'd2, 12'h014, 0, 1, 32'hDEADAAEF);

        // A store sampled while reset is high must be dropped.
        @(negedge clk);
        rst = 1'b1;
        mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'd2; address = 12'h014;
        write_data = 32'h12345678;
        @(negedge clk);
        rst = 1'b0;
        mem_write = 1'b0;
        rd_model = 32'b0;
        req(0, 1, 3'd2, 12'h014, 0, 1, 32'hDEADAAEF);

        for (int i = 0; i < 400; i++) begin
            logic wr, rd;
            wr = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) != 0);
            req(wr, rd, f3_list[$urandom_range(0, 5)], {4'b0, 8'($urandom)}, $urandom, 0, 0);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
